// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register: valid/ready handshake with a 2-entry skid buffer (O + S).
// Optional MA_WB_STALL_CNT_EN adds a saturating 16-bit write-back stall counter.
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [DATA_W-1:0] fwd_value
`ifdef MA_WB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read_value;
    logic [REG_W-1:0]  dest;
  } beat_t;

  beat_t in_beat, o_q, s_q, o_d, s_d;
  logic  o_vld, s_vld, o_vld_d, s_vld_d;
  logic  acc, o_free;

  assign in_beat = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, alu_result: alu_result_in,
                     mem_read_value: mem_read_value_in, dest: dest_in};
  assign acc    = in_valid && in_ready;
  assign o_free = !o_vld || out_ready;

  always_comb begin
    o_d     = o_q;
    s_d     = s_q;
    o_vld_d = o_vld;
    s_vld_d = s_vld;
    if (flush) begin
      // payload deliberately held; only occupancy is dropped
      o_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (o_free) begin
      if (s_vld) begin
        o_d     = s_q;
        o_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (acc) begin
        o_d     = in_beat;
        o_vld_d = 1'b1;
      end else begin
        o_vld_d = 1'b0;
      end
    end else if (acc) begin
      s_d     = in_beat;
      s_vld_d = 1'b1;
    end
  end

  // in_ready is registered from the next skid state, so it never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q      <= '0;
      s_q      <= '0;
      o_vld    <= 1'b0;
      s_vld    <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      o_q      <= o_d;
      s_q      <= s_d;
      o_vld    <= o_vld_d;
      s_vld    <= s_vld_d;
      in_ready <= !s_vld_d;
    end
  end

  assign out_valid      = o_vld;
  assign wb_en          = o_q.wb_en;
  assign mem_r_en       = o_q.mem_r_en;
  assign alu_result     = o_q.alu_result;
  assign mem_read_value = o_q.mem_read_value;
  assign dest           = o_q.dest;
  assign wb_value       = o_q.mem_r_en ? o_q.mem_read_value : o_q.alu_result;
  assign fwd_valid      = o_vld && o_q.wb_en;
  assign fwd_dest       = o_q.dest;
  assign fwd_value      = wb_value;

`ifdef MA_WB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (o_vld && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: FIFO scoreboard of accepted beats checked against the outputs.
module tb_mem_wb_skid_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic              wb_en_in, mem_r_en_in, wb_en, mem_r_en, fwd_valid;
  logic [DATA_W-1:0] alu_result_in, mem_read_value_in, alu_result, mem_read_value, wb_value, fwd_value;
  logic [REG_W-1:0]  dest_in, dest, fwd_dest;
`ifdef MA_WB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
    .mem_read_value_in(mem_read_value_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
    .mem_read_value(mem_read_value), .dest(dest), .wb_value(wb_value),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
`ifdef MA_WB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mrv;
    logic [REG_W-1:0]  dest;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic mr,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mrv,
                       input logic [REG_W-1:0] d);
    in_valid = v; wb_en_in = we; mem_r_en_in = mr;
    alu_result_in = alu; mem_read_value_in = mrv; dest_in = d;
  endtask

  // Score the current cycle against the model, then advance one clock.
  task automatic cycle();
    beat_t e;
    logic  acc;
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
      if (q.size() > 0) begin
        e = q[0];
        chk("payload", {wb_en, mem_r_en, alu_result[15:0], mem_read_value[15:0], dest},
                       {e.wb_en, e.mem_r_en, e.alu[15:0], e.mrv[15:0], e.dest});
        chk("wb_value",  {32'd0, wb_value},  {32'd0, e.mem_r_en ? e.mrv : e.alu});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.wb_en});
        chk("fwd_dest",  {60'd0, fwd_dest},  {60'd0, e.dest});
        chk("fwd_value", {32'd0, fwd_value}, {32'd0, e.mem_r_en ? e.mrv : e.alu});
      end
      acc = in_valid && (q.size() < 2);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) begin
        q.push_back('{wb_en_in, mem_r_en_in, alu_result_in, mem_read_value_in, dest_in});
        last_acc = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_alu", {32'd0, alu_result}, 64'd0);
    chk("rst_wb_value", {32'd0, wb_value}, 64'd0);
    cycle();

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, DATA_W'(i), 32'hF0 + DATA_W'(i), REG_W'(i));
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      cycle();
      chk("stream_latency", {32'd0, alu_result}, 64'(i));
    end
    drain();

    // skid: A, B absorbed under back-pressure, C waits upstream
    out_ready = 1'b0;
    drive(1, 1, 0, 32'h11, 32'h0, 4'd1); cycle();
    drive(1, 1, 0, 32'h22, 32'h0, 4'd2); cycle();
    drive(1, 0, 0, 32'h33, 32'h0, 4'd3); cycle();
    chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
    chk("skid_head", {32'd0, alu_result}, 64'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_acc) break;
    end
    chk("skid_c_accepted", {63'd0, last_acc}, 64'd1);
    drain();

    // write-back select and forwarding tap
    out_ready = 1'b1;
    drive(1, 1, 1, 32'h1000, 32'hDEAD, 4'd5); cycle();
    chk("sel_load", {32'd0, wb_value}, 64'hDEAD);
    chk("fwd_valid_5", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_dest_5", {60'd0, fwd_dest}, 64'd5);
    drive(1, 0, 0, 32'h1000, 32'hDEAD, 4'd6); cycle();
    chk("sel_alu", {32'd0, wb_value}, 64'h1000);
    chk("fwd_valid_off", {63'd0, fwd_valid}, 64'd0);
    drain();

    // flush with O and S full and a beat offered
    out_ready = 1'b0;
    drive(1, 1, 0, 32'hA1, 0, 4'd7); cycle();
    drive(1, 1, 0, 32'hA2, 0, 4'd8); cycle();
    drive(1, 1, 0, 32'hA3, 0, 4'd9); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    // flush with S empty while a beat is acceptable: it must still be dropped
    drive(1, 1, 0, 32'hB1, 0, 4'd1); cycle();
    drive(1, 1, 0, 32'hB2, 0, 4'd2); flush = 1'b1; cycle();
    flush = 1'b0;
    drive(1, 1, 0, 32'hC1, 0, 4'd3); out_ready = 1'b1; cycle();
    drain();

    // reset mid-stream
    out_ready = 1'b0;
    drive(1, 1, 0, 32'h51, 0, 4'd1); cycle();
    drive(1, 1, 0, 32'h52, 0, 4'd2); cycle();
    drive(1, 1, 0, 32'h53, 0, 4'd3); cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_alu", {32'd0, alu_result}, 64'd0);
    chk("midrst_dest", {60'd0, dest}, 64'd0);
    cycle();

`ifdef MA_WB_STALL_CNT_EN
    chk("cnt_reset", {48'd0, stall_cnt}, 64'd0);
    out_ready = 1'b0;
    drive(1, 1, 0, 32'h77, 0, 4'd4); cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    chk("cnt_10", {48'd0, stall_cnt}, 64'd10);
    repeat (65530) cycle();
    chk("cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);
    flush = 1'b1; cycle();
    flush = 1'b0; cycle();
    chk("cnt_after_flush", {48'd0, stall_cnt}, 64'hFFFF);
    rst = 1'b1; cycle();
    rst = 1'b0;
    chk("cnt_rst", {48'd0, stall_cnt}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
